rv_div: RTL

Iterative RV32M divide/remainder unit (DIV, DIVU, REM, REMU). It sits downstream of the register file read ports: it takes rs1/rs2 read data plus the destination index, runs a 32-step restoring division, and presents the result on a register-file write port. The write port is shaped as wen/waddr/wdata so it connects straight to the register file write port. While busy it back-pressures decode with a valid/ready handshake.

---
 rtl/rv_div_if.sv | 26 ++
 rtl/rv_div.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/rv_div_if.sv
// Request/result bundle for the iterative RV32M divider.
// Handshake: a request transfers on a rising edge where i_valid & o_ready & ~i_kill are all high; o_ready is high only while idle.
interface rv_div_if;
   logic        i_valid;
   logic        o_ready;
   logic [1:0]  i_op;
   logic [31:0] i_rs1_rdata;
   logic [31:0] i_rs2_rdata;
   logic [4:0]  i_rd_waddr;
   logic        i_kill;
   logic        o_busy;
   logic        o_rd_wen;
   logic [4:0]  o_rd_waddr;
   logic [31:0] o_rd_wdata;
   logic [1:0]  o_dbg_state;

   modport master (
      output i_valid, i_op, i_rs1_rdata, i_rs2_rdata, i_rd_waddr, i_kill,
      input  o_ready, o_busy, o_rd_wen, o_rd_waddr, o_rd_wdata, o_dbg_state
   );

   modport slave (
      input  i_valid, i_op, i_rs1_rdata, i_rs2_rdata, i_rd_waddr, i_kill,
      output o_ready, o_busy, o_rd_wen, o_rd_waddr, o_rd_wdata, o_dbg_state
   );
endinterface

// File: rtl/rv_div.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit: 32-step restoring division on operand
// magnitudes, sign fixup on the last step, result on a register-file write port.
module rv_div #(
   parameter bit FAST_SPECIAL = 1'b1
) (
   input  logic     i_clk,
   input  logic     i_rst_n,
   rv_div_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      state;
   logic [5:0]  cnt;
   logic        rem_sel_q;
   logic        neg_quot_q;
   logic        neg_rem_q;
   logic [31:0] quot_q;
   logic [31:0] rem_q;
   logic [31:0] dvs_q;
   logic [4:0]  waddr_q;
   logic [4:0]  out_waddr_q;
   logic [31:0] out_wdata_q;

   // Request decode (only meaningful in IDLE)
   logic        is_signed;
   logic        a_neg;
   logic        b_neg;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic        div_zero;
   logic        ovf;
   logic        special;
   logic [31:0] fast_res;
   logic        accept;

   always_comb begin
      is_signed = ~bus.i_op[0];
      a_neg     = is_signed & bus.i_rs1_rdata[31];
      b_neg     = is_signed & bus.i_rs2_rdata[31];
      a_mag     = a_neg ? (~bus.i_rs1_rdata + 32'd1) : bus.i_rs1_rdata;
      b_mag     = b_neg ? (~bus.i_rs2_rdata + 32'd1) : bus.i_rs2_rdata;
      div_zero  = (bus.i_rs2_rdata == 32'd0);
      ovf       = is_signed & (bus.i_rs1_rdata == 32'h8000_0000) &
                  (bus.i_rs2_rdata == 32'hFFFF_FFFF);
      special   = div_zero | ovf;
      if (bus.i_op[1])
         fast_res = div_zero ? bus.i_rs1_rdata : 32'd0;
      else
         fast_res = div_zero ? 32'hFFFF_FFFF : 32'h8000_0000;
      accept    = (state == S_IDLE) & bus.i_valid & ~bus.i_kill;
   end

   // One restoring step plus the signed result it would produce if it were the last
   logic [32:0] rem_sh;
   logic [32:0] diff;
   logic        ge;
   logic [31:0] rem_nx;
   logic [31:0] quot_nx;
   logic [31:0] quot_fix;
   logic [31:0] rem_fix;
   logic [31:0] final_res;

   always_comb begin
      rem_sh    = {rem_q, quot_q[31]};
      diff      = rem_sh - {1'b0, dvs_q};
      ge        = ~diff[32];
      rem_nx    = ge ? diff[31:0] : rem_sh[31:0];
      quot_nx   = {quot_q[30:0], ge};
      quot_fix  = neg_quot_q ? (~quot_nx + 32'd1) : quot_nx;
      rem_fix   = neg_rem_q  ? (~rem_nx + 32'd1)  : rem_nx;
      final_res = rem_sel_q ? rem_fix : quot_fix;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state       <= S_IDLE;
         cnt         <= 6'd0;
         rem_sel_q   <= 1'b0;
         neg_quot_q  <= 1'b0;
         neg_rem_q   <= 1'b0;
         quot_q      <= 32'd0;
         rem_q       <= 32'd0;
         dvs_q       <= 32'd0;
         waddr_q     <= 5'd0;
         out_waddr_q <= 5'd0;
         out_wdata_q <= 32'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  rem_sel_q <= bus.i_op[1];
                  waddr_q   <= bus.i_rd_waddr;
                  if (FAST_SPECIAL && special) begin
                     state       <= S_DONE;
                     out_wdata_q <= fast_res;
                     out_waddr_q <= bus.i_rd_waddr;
                  end else begin
                     state      <= S_CALC;
                     cnt        <= 6'd0;
                     quot_q     <= a_mag;
                     rem_q      <= 32'd0;
                     dvs_q      <= b_mag;
                     // Divide-by-zero keeps the all-ones quotient unnegated
                     neg_quot_q <= (a_neg ^ b_neg) & ~div_zero;
                     neg_rem_q  <= a_neg;
                  end
               end
            end
            S_CALC: begin
               if (bus.i_kill) begin
                  state <= S_IDLE;
               end else begin
                  quot_q <= quot_nx;
                  rem_q  <= rem_nx;
                  cnt    <= cnt + 6'd1;
                  if (cnt == 6'd31) begin
                     state       <= S_DONE;
                     out_wdata_q <= final_res;
                     out_waddr_q <= waddr_q;
                  end
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Kill reaches the write enable combinationally so a flush in DONE drops the write
   always_comb begin
      bus.o_ready     = (state == S_IDLE);
      bus.o_busy      = (state != S_IDLE);
      bus.o_rd_wen    = (state == S_DONE) & ~bus.i_kill & (out_waddr_q != 5'd0);
      bus.o_rd_waddr  = out_waddr_q;
      bus.o_rd_wdata  = out_wdata_q;
      bus.o_dbg_state = state;
   end

endmodule
